// File: rtl/qdiv_seq.sv
// Sequential sign-magnitude fixed-point divider (restoring, one quotient bit per clock).
// Optional round-half-up on magnitude: define QDIV_ROUND_EN.
module qdiv_seq #(
    parameter int Q = 15,
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] i_dividend,
    input  logic [N-1:0] i_divisor,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] o_quotient,
    output logic         o_ovr,
    output logic         o_dbz
);

    localparam int M = N - 1;
`ifdef QDIV_ROUND_EN
    localparam int ITER = N + Q;
`else
    localparam int ITER = N - 1 + Q;
`endif
    localparam int CW = $clog2(ITER);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    rem_q, rem_d;
    logic [ITER-1:0] num_q, num_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [M-1:0]    dv_q, dv_d;
    logic            sgn_q, sgn_d;
    logic [N-1:0]    quo_q, quo_d;
    logic            ovr_q, ovr_d;
    logic            dbz_q, dbz_d;

    logic            dv_zero;
    logic            in_sgn;
    logic [ITER-1:0] numer;
    logic            qb_a, qb_c;
    logic [N-1:0]    rem_a, rem_c;
    logic [ITER-1:0] raw;
    logic [M-1:0]    res_mag;
    logic            res_ovr;
    logic            res_sgn;

    // One restoring step: returns {quotient bit, new remainder}.
    function automatic logic [N:0] div_step(input logic [N-1:0] rem,
                                            input logic         nb,
                                            input logic [M-1:0] dv);
        logic [N-1:0] sh;
        logic         qb;
        sh = {rem[N-2:0], nb};
        qb = ({rem, nb} >= {2'b00, dv});
        return {qb, qb ? (sh - {1'b0, dv}) : sh};
    endfunction

    assign dv_zero = (i_divisor[M-1:0] == '0);
    assign in_sgn  = i_dividend[N-1] ^ i_divisor[N-1];
    assign numer   = {i_dividend[M-1:0], {(ITER-M){1'b0}}};

    // The first (trivial) iteration is folded into the accept edge so that
    // out_valid appears a fixed ITER cycles after accept.
    assign {qb_a, rem_a} = div_step('0, numer[ITER-1], i_divisor[M-1:0]);
    assign {qb_c, rem_c} = div_step(rem_q, num_q[ITER-1], dv_q);
    assign raw = {num_q[ITER-2:0], qb_c};

`ifdef QDIV_ROUND_EN
    logic [M:0] rnd;
    logic       sat;
    always_comb begin
        sat     = |raw[ITER-1:M+1];
        rnd     = {1'b0, raw[M:1]} + {{M{1'b0}}, raw[0]};
        res_ovr = sat | rnd[M];
        res_mag = res_ovr ? '1 : rnd[M-1:0];
    end
`else
    always_comb begin
        res_ovr = |raw[ITER-1:M];
        res_mag = res_ovr ? '1 : raw[M-1:0];
    end
`endif

    assign res_sgn = sgn_q & (|res_mag);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = dv_zero ? DONE : CALC;
            CALC:    if (cnt_q == CW'(1)) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    always_comb begin
        rem_d = rem_q;
        num_d = num_q;
        cnt_d = cnt_q;
        dv_d  = dv_q;
        sgn_d = sgn_q;
        quo_d = quo_q;
        ovr_d = ovr_q;
        dbz_d = dbz_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sgn_d = in_sgn;
                    dv_d  = i_divisor[M-1:0];
                    if (dv_zero) begin
                        quo_d = {in_sgn, {M{1'b1}}};
                        ovr_d = 1'b1;
                        dbz_d = 1'b1;
                    end else begin
                        rem_d = rem_a;
                        num_d = {numer[ITER-2:0], qb_a};
                        cnt_d = CW'(ITER - 1);
                    end
                end
            end
            CALC: begin
                rem_d = rem_c;
                num_d = raw;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    quo_d = {res_sgn, res_mag};
                    ovr_d = res_ovr;
                    dbz_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q <= '0;
            num_q <= '0;
            cnt_q <= '0;
            dv_q  <= '0;
            sgn_q <= 1'b0;
            quo_q <= '0;
            ovr_q <= 1'b0;
            dbz_q <= 1'b0;
        end else begin
            rem_q <= rem_d;
            num_q <= num_d;
            cnt_q <= cnt_d;
            dv_q  <= dv_d;
            sgn_q <= sgn_d;
            quo_q <= quo_d;
            ovr_q <= ovr_d;
            dbz_q <= dbz_d;
        end
    end

    assign o_quotient = quo_q;
    assign o_ovr      = ovr_q;
    assign o_dbz      = dbz_q;

endmodule

// File: tb/tb_qdiv_seq.sv
// Self-checking bench for qdiv_seq: vector table through a scoreboard queue,
// plus back-pressure and mid-calculation reset sequences.
module tb_qdiv_seq;

    localparam int N = 32;
    localparam int Q = 15;
`ifdef QDIV_ROUND_EN
    localparam int LAT = N + Q;
    localparam logic [N-1:0] ONE_THIRD = 32'h00002AAB;
`else
    localparam int LAT = N - 1 + Q;
    localparam logic [N-1:0] ONE_THIRD = 32'h00002AAA;
`endif
    localparam int LIMIT = 200;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] i_dividend;
    logic [N-1:0] i_divisor;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] o_quotient;
    logic         o_ovr;
    logic         o_dbz;

    qdiv_seq #(.Q(Q), .N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .i_dividend(i_dividend),
        .i_divisor (i_divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .o_quotient(o_quotient),
        .o_ovr     (o_ovr),
        .o_dbz     (o_dbz)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] q;
        logic         ovr;
        logic         dbz;
        int           lat;
    } vec_t;

    vec_t vecs[11];
    vec_t exq[$];
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one operand pair, push its expectation on the accept edge.
    task automatic issue(input vec_t v);
        @(negedge clk);
        i_dividend = v.a;
        i_divisor  = v.b;
        in_valid   = 1'b1;
        chk("in_ready_before_accept", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        exq.push_back(v);
        #1;
        in_valid   = 1'b0;
        i_dividend = $urandom();
        i_divisor  = $urandom();
    endtask

    // Count cycles from accept until out_valid, bounded.
    task automatic await_result(output int lat);
        lat = 1;
        while (!out_valid && lat < LIMIT) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!out_valid) chk("out_valid_timeout", {63'd0, out_valid}, 64'd1);
    endtask

    task automatic check_result(input string tag, input int lat, output vec_t e);
        if (exq.size() == 0) begin
            chk({tag, "_scoreboard_empty"}, 64'd0, 64'd1);
            e = '{default: '0};
        end else begin
            e = exq.pop_front();
            chk({tag, "_quotient"}, {32'd0, o_quotient}, {32'd0, e.q});
            chk({tag, "_ovr"}, {63'd0, o_ovr}, {63'd0, e.ovr});
            chk({tag, "_dbz"}, {63'd0, o_dbz}, {63'd0, e.dbz});
            chk({tag, "_latency"}, 64'(lat), 64'(e.lat));
        end
    endtask

    task automatic handshake(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, "_idle_out_valid"}, {63'd0, out_valid}, 64'd0);
        chk({tag, "_idle_in_ready"}, {63'd0, in_ready}, 64'd1);
    endtask

    initial begin
        vec_t e;
        int   lat;
        int   stale;

        vecs[0]  = '{32'h00030000, 32'h00010000, 32'h00018000, 1'b0, 1'b0, LAT};
        vecs[1]  = '{32'h8000C000, 32'h00004000, 32'h80018000, 1'b0, 1'b0, LAT};
        vecs[2]  = '{32'h80000000, 32'h00008000, 32'h00000000, 1'b0, 1'b0, LAT};
        vecs[3]  = '{32'h00008000, 32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b1, 1};
        vecs[4]  = '{32'h40000000, 32'h00004000, 32'h7FFFFFFF, 1'b1, 1'b0, LAT};
        vecs[5]  = '{32'h00008000, 32'h00018000, ONE_THIRD,    1'b0, 1'b0, LAT};
        vecs[6]  = '{32'h80010000, 32'h80008000, 32'h00010000, 1'b0, 1'b0, LAT};
        vecs[7]  = '{32'h00004000, 32'h00008000, 32'h00004000, 1'b0, 1'b0, LAT};
        vecs[8]  = '{32'h7FFFFFFF, 32'h00008000, 32'h7FFFFFFF, 1'b0, 1'b0, LAT};
        vecs[9]  = '{32'h80008000, 32'h80000000, 32'h7FFFFFFF, 1'b1, 1'b1, 1};
        vecs[10] = '{32'h00000001, 32'h00000001, 32'h00008000, 1'b0, 1'b0, LAT};

        rst_n      = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        i_dividend = '0;
        i_divisor  = '0;
        #12;
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_quotient", {32'd0, o_quotient}, 64'd0);
        chk("rst_ovr_dbz", {62'd0, o_ovr, o_dbz}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            issue(vecs[i]);
            await_result(lat);
            check_result($sformatf("vec%0d", i), lat, e);
            handshake($sformatf("vec%0d", i));
        end

        // Back-pressure: result held 10 cycles, new operands ignored.
        issue(vecs[4]);
        await_result(lat);
        check_result("hold", lat, e);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            in_valid   = 1'b1;
            i_dividend = 32'h00030000;
            i_divisor  = 32'h00010000;
            @(posedge clk);
            #1;
            chk($sformatf("hold%0d_quotient", c), {32'd0, o_quotient}, {32'd0, e.q});
            chk($sformatf("hold%0d_ovr", c), {63'd0, o_ovr}, {63'd0, e.ovr});
            chk($sformatf("hold%0d_valid_ready", c), {62'd0, out_valid, in_ready}, 64'd2);
        end
        @(negedge clk);
        in_valid = 1'b0;
        handshake("hold");
        issue(vecs[5]);
        await_result(lat);
        check_result("after_hold", lat, e);
        handshake("after_hold");

        // Reset in the middle of a calculation.
        issue(vecs[1]);
        repeat (19) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("midrst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("midrst_quotient", {32'd0, o_quotient}, 64'd0);
        chk("midrst_ovr_dbz", {62'd0, o_ovr, o_dbz}, 64'd0);
        exq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        stale = 0;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk);
            #1;
            if (out_valid) stale++;
        end
        chk("midrst_no_stale_valid", 64'(stale), 64'd0);
        issue(vecs[0]);
        await_result(lat);
        check_result("after_rst", lat, e);
        handshake("after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/qdiv_seq.md
Name: qdiv_seq

Overview:
- Sequential fixed-point divider: quotient = dividend / divisor. It is the inverse datapath to the multiply-accumulate (FMA) path.
- Number format matches the qmult/qadd units: sign-magnitude, N bits total, MSB is the sign, Q fractional bits, N-1 magnitude bits.
- Restoring division, one quotient bit per clock. Valid/ready handshake on both input and output.
- Feeds normalisation and reciprocal steps in the fixed-point compute pipeline.

Parameters:
- Q, 15, number of fractional bits (1 <= Q <= N-2).
- N, 32, total word width including the sign bit.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands present on i_dividend and i_divisor.
- in_ready  output  1  block can accept operands.
- i_dividend  input  N  sign-magnitude dividend.
- i_divisor  input  N  sign-magnitude divisor.
- out_valid  output  1  result fields are valid.
- out_ready  input  1  consumer accepts the result.
- o_quotient  output  N  sign-magnitude quotient.
- o_ovr  output  1  quotient magnitude saturated (overflow).
- o_dbz  output  1  divisor magnitude was zero.

Behaviour:
- Reset (async assert, sync deassert by the system):
  - state = IDLE, in_ready = 1, out_valid = 0.
  - o_quotient = 0, o_ovr = 0, o_dbz = 0.
  - Iteration counter, remainder and working registers = 0.
- States: IDLE, CALC, DONE.
- IDLE:
  - in_ready = 1.
  - On an edge with in_valid=1, capture both operands:
    - Sign = dividend[N-1] XOR divisor[N-1].
    - Working numerator = {dividend magnitude, Q zeros}, width N-1+Q.
  - If the divisor magnitude is 0, go to DONE. Result fields: o_dbz = 1, o_ovr = 1, o_quotient = {sign, all ones}. out_valid is seen 1 cycle after accept.
  - Otherwise go to CALC with counter = N-1+Q.
- CALC:
  - in_ready = 0.
  - Each edge: shift the next numerator bit into an N-bit remainder. Trial-subtract the divisor magnitude. If non-negative, keep the difference and the quotient bit = 1; otherwise restore and the quotient bit = 0. Decrement the counter.
  - After the edge that produces the last bit, go to DONE.
  - Latency from the accept edge to out_valid = N-1+Q cycles (46 at defaults). Latency is fixed and independent of the data.
- Result formation, registered on entry to DONE:
  - The raw quotient is N-1+Q bits wide.
  - If any bit above bit N-2 is set: o_ovr = 1 and the magnitude saturates to all ones (N-1 bits).
  - Else the magnitude = the low N-1 bits.
  - If the final magnitude is 0, the sign is forced to 0 (no negative zero).
- DONE:
  - out_valid = 1, in_ready = 0.
  - o_quotient, o_ovr and o_dbz stay stable until an edge with out_ready=1. That edge moves to IDLE and clears out_valid.
  - The result registers keep their last values in IDLE. No back-to-back accept from DONE: a new operand pair is accepted no earlier than the first IDLE cycle.
- Inputs are ignored while not in IDLE. Changing i_dividend or i_divisor during CALC has no effect.
- Reset asserted during CALC or DONE: immediate return to reset values. The in-flight operation is discarded and no out_valid pulse is produced.
- Internal widths: remainder N bits (divisor magnitude plus one guard bit); no other intermediate truncation.

Optional Feature:
- Macro: QDIV_ROUND_EN.
- Defined:
  - CALC runs N+Q iterations, producing one extra guard bit below the LSB. Latency = N+Q cycles.
  - Magnitude = truncated value + guard bit (round half up on magnitude, i.e. away from zero in signed terms).
  - If this increment carries beyond N-1 bits, or the value was already saturated, the result is {sign, all ones} with o_ovr = 1.
- Undefined: truncation toward zero, N-1+Q iterations.

Test Plan:
- Q=15, N=32: dividend 0x00030000 (6.0), divisor 0x00010000 (2.0) -> o_quotient 0x00018000 (3.0), o_ovr=0, o_dbz=0, out_valid exactly 46 cycles after accept.
- Dividend 0x8000C000 (-1.5), divisor 0x00004000 (0.5) -> 0x80018000 (-3.0). Dividend 0x80000000 (-0), divisor 0x00008000 -> 0x00000000 with sign cleared.
- Dividend 0x00008000, divisor 0x80000000 -> o_dbz=1, o_ovr=1, o_quotient 0xFFFFFFFF, out_valid 1 cycle after accept. Dividend 0x40000000 (32768.0), divisor 0x00004000 (0.5) -> o_ovr=1, o_dbz=0, o_quotient 0x7FFFFFFF.
- Dividend 0x00008000 (1.0), divisor 0x00018000 (3.0) -> 0x00002AAA without QDIV_ROUND_EN; 0x00002AAB with it, latency 47.
- Hold out_ready=0 for 10 cycles in DONE -> outputs stable, in_ready=0, a new in_valid is ignored. Release -> IDLE next cycle, then the next operand pair is accepted and computed correctly.
- Assert rst_n=0 at CALC cycle 20 -> all outputs return to reset values asynchronously. After release, no stale out_valid; a fresh 6.0/2.0 returns 0x00018000.
